// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating multiplexer:
// index-width helpers and the packet-lock state encoding.
package rr_arb_mux_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Channel index is at least one bit wide so N=1 still has a legal port.
    function automatic int sel_w(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb_mux_if.sv
// Bundles the N input valid/ready channels and the single registered
// output channel of rr_arb_mux.
interface rr_arb_mux_if
    import rr_arb_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) ();
    localparam int SEL_W = sel_w(N);

    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_last;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/rr_arb_mux_pick.sv
// Combinational rotating priority encoder: first set request at or above
// ptr, wrapping from N-1 back to 0.
module rr_pick
    import rr_arb_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);
    logic [2*N-1:0]   masked_s;
    logic             hit_s;
    logic [SEL_W-1:0] idx_s;

    // Masking the low copy below ptr lets the upper copy supply the wrapped search.
    always_comb begin
        masked_s = {req, req} & ({(2*N){1'b1}} << ptr);
        hit_s    = 1'b0;
        idx_s    = '0;
        for (int i = 0; i < 2*N; i++) begin
            if (masked_s[i] && !hit_s) begin
                hit_s = 1'b1;
                idx_s = SEL_W'(i % N);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // One-hot form of the winning index.
    always_comb begin
        gnt_onehot = '0;
        for (int j = 0; j < N; j++) begin
            gnt_onehot[j] = hit_s && (idx_s == SEL_W'(j));
        end
    end

    assign gnt_idx = idx_s;
    assign any     = |req;

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating multiplexer with a registered output
// stage and optional packet lock that holds a grant until the last beat.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int LOCK = 0
) (
    input  logic         clk,
    input  logic         rst,
    rr_arb_mux_if.slave  bus
);
    localparam int SEL_W = sel_w(N);

    state_t           state_r, state_nx_s;
    logic [SEL_W-1:0] lock_ch_r, ptr_r, ptr_nx_s;
    logic             out_valid_r, out_last_r;
    logic [W-1:0]     out_data_r;
    logic [SEL_W-1:0] out_sel_r;

    logic [N-1:0]     lock_mask_s, elig_s, gnt_oh_s, in_ready_s;
    logic [SEL_W-1:0] gnt_idx_s;
    logic             any_s, slot_free_s, xfer_s, last_s, leave_s;
    logic [W-1:0]     data_s;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req        (elig_s),
        .ptr        (ptr_r),
        .gnt_onehot (gnt_oh_s),
        .gnt_idx    (gnt_idx_s),
        .any        (any_s)
    );

    assign elig_s      = bus.in_valid & lock_mask_s;
    assign slot_free_s = !out_valid_r || bus.out_ready;
    assign xfer_s      = slot_free_s && any_s && !rst;
    assign data_s      = bus.in_data[int'(gnt_idx_s)*W +: W];
    assign last_s      = bus.in_last[gnt_idx_s];
    assign leave_s     = (state_r == LOCKED) && xfer_s && last_s;

    // Ready goes only to the granted channel, and never while in reset.
    always_comb begin
        if (rst || !slot_free_s) begin
            in_ready_s = '0;
        end else begin
            in_ready_s = gnt_oh_s;
        end
    end

    // Lock state register and locked channel capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            lock_ch_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if ((state_r == IDLE) && xfer_s && !last_s) begin
                lock_ch_r <= gnt_idx_s;
            end
        end
    end

    // Lock next-state: only multi-beat packets enter LOCKED.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if ((LOCK != 0) && xfer_s && !last_s) begin
                    state_nx_s = LOCKED;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOCKED: begin
                if (xfer_s && last_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = LOCKED;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Lock output: in LOCKED only the owning channel stays eligible.
    always_comb begin
        lock_mask_s = '1;
        case (state_r)
            IDLE: lock_mask_s = '1;
            LOCKED: begin
                for (int i = 0; i < N; i++) begin
                    lock_mask_s[i] = (lock_ch_r == SEL_W'(i));
                end
            end
            default: lock_mask_s = '1;
        endcase
    end

    // Pointer moves past the winner, but not on the beat that ends a lock.
    always_comb begin
        if (xfer_s && !leave_s) begin
            if (gnt_idx_s == SEL_W'(N-1)) begin
                ptr_nx_s = '0;
            end else begin
                ptr_nx_s = gnt_idx_s + SEL_W'(1);
            end
        end else begin
            ptr_nx_s = ptr_r;
        end
    end

    // Pointer and output pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_sel_r   <= '0;
        end else begin
            ptr_r <= ptr_nx_s;
            if (slot_free_s) begin
                if (any_s) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= data_s;
                    out_last_r  <= last_s;
                    out_sel_r   <= gnt_idx_s;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_sel   = out_sel_r;

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the 2:1 mux: N-channel, W-bit-wide multiplexer.
- Selection is made by an internal round-robin arbiter instead of an external sel line.
- Every channel uses a valid/ready handshake; the output is a registered pipeline stage.
- Optional packet-lock mode holds a grant until the packet completes. Used to merge request streams (e.g. bus masters, trace sources) onto one downstream port.

Parameters:
- N, 4, number of input channels (>=1).
- W, 8, data width in bits (>=1).
- LOCK, 0, 1 = grant held from first beat until an accepted beat with in_last=1; 0 = arbitrate every beat.
- SEL_W, derived = max(1, clog2(N)), width of channel index.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N  per-channel request; bit i = channel i.
- in_data  in  N*W  flattened; channel i occupies bits [i*W +: W].
- in_last  in  N  end-of-packet flag per channel (ignored when LOCK=0).
- in_ready  out  N  per-channel accept; at most one bit high.
- out_valid  out  1  output register holds a beat.
- out_data  out  W  registered data of accepted beat.
- out_last  out  1  registered in_last of accepted beat.
- out_sel  out  SEL_W  registered index of source channel.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, state=IDLE. Reset wins over any simultaneous transfer, including mid-packet.
- Transfer rules: input transfer on channel i when in_valid[i] & in_ready[i]; output transfer when out_valid & out_ready.
- slot_free = !out_valid | out_ready. Full throughput: one beat per cycle while out_ready=1.
- Eligible set E:
  - state=IDLE (or LOCK=0): E = in_valid.
  - state=LOCKED: E = in_valid & onehot(lock_ch).
- Grant: g = first set bit of E searching upward from ptr, wrapping N-1 -> 0. in_ready[g] = slot_free & |E. This is combinational; ready may depend on valid, valid must never depend on ready.
- On input transfer from g at edge:
  - out_data<=in_data[g], out_last<=in_last[g], out_sel<=g, out_valid<=1.
  - ptr<=(g+1) mod N, except when the transfer leaves state LOCKED (ptr then unchanged).
- slot_free with no eligible request: out_valid<=0, and out_data/out_last/out_sel hold.
- !slot_free (out_valid=1, out_ready=0): all output registers hold stable, all in_ready=0.
- Latency: one cycle from input transfer to out_valid.
- Lock FSM (LOCK=1 only; with LOCK=0 state stays IDLE):
  - IDLE -> LOCKED on transfer with in_last[g]=0; lock_ch<=g.
  - LOCKED -> IDLE on transfer from lock_ch with in_last=1.
  - Single-beat packet (last=1 in IDLE) stays IDLE.
  - In LOCKED, other channels are starved even if lock_ch drops valid.
- N=1: ptr and out_sel are constant 0; the block degenerates to a registered valid/ready stage.
- Fairness: with all N requesting continuously and out_ready=1, each channel is granted exactly once per N cycles.

Decomposition:
- Shared package/include (mux_defs): clog2 function, SEL_W derivation, state encodings IDLE=1'b0 and LOCKED=1'b1.
- One sub-module, rr_pick: combinational rotating priority encoder.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: gnt_onehot[N], gnt_idx[SEL_W], any.
  - Implemented with a double-width mask trick.
- Top holds the output register, ptr, and the lock FSM.

Test Plan (N=4, W=8):
- Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 during reset; first grant after release = ch0.
- Round-robin: all in_valid=1, data ch0..3=0xA0..0xA3, out_ready=1, LOCK=0 -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; out_sel 0,1,2,3,0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_sel stable, in_ready=4'b0000; on out_ready=1, next beat accepted the same cycle, no loss or duplication.
- Wrap/sparse: ptr=3, only ch1 and ch2 valid -> grant ch1, then ch2, then ch1; a lone request on ch3 is granted within 1 cycle.
- Lock (LOCK=1): ch2 sends 3-beat packet (last on beat 3) while ch0 continuously valid -> out_sel=2,2,2 then 0; ch2 valid gap mid-packet keeps ch0 blocked.
- Reset mid-packet (LOCK=1): assert rst after beat 1 of ch1 packet -> state IDLE, out_valid=0; after release ch0 granted first (ptr=0).
